moesif_snoopy_responder: RTL



---
 rtl/moesif_snoopy_responder_pkg.sv | 14 +
 rtl/moesif_snoop_state_update.sv | 17 +
 rtl/moesif_snoopy_responder.sv | 119 +++++++++++
 3 files changed

// File: rtl/moesif_snoopy_responder_pkg.sv
// moesif_snoopy_responder_pkg: line states, bus commands and snoop decode helpers
package moesif_snoopy_responder_pkg;
  typedef enum logic [2:0] {MODIFIED, OWNED, EXCLUSIVE, SHARED, INVALID, FORWARD} CacheLineState;
  typedef enum logic [1:0] {BUS_READ, BUS_READ_EXCLUSIVE, BUS_INVALIDATE} BusCommand;
  typedef enum logic [2:0] {IDLE, ARBITRATE, LOOKUP, SUPPLY, UPDATE, DONE} snoop_state_t;
  function automatic logic suppliesData(CacheLineState s);
    return s inside {MODIFIED, OWNED, EXCLUSIVE, FORWARD};
  endfunction
  function automatic CacheLineState snoopNextState(BusCommand c, CacheLineState s);
    if (c != BUS_READ || s == INVALID) return INVALID;
    if (s == MODIFIED || s == OWNED) return OWNED;
    return SHARED;
  endfunction
endpackage

// File: rtl/moesif_snoop_state_update.sv
// moesif_snoop_state_update: combinational hit qualification, supply and next-state decode
module moesif_snoop_state_update
  import moesif_snoopy_responder_pkg::*;
(
  input  BusCommand     command,
  input  CacheLineState state_in,
  input  logic          hit_in,
  output logic          hit,
  output logic          supply,
  output CacheLineState next_state
);
  always_comb begin
    hit = hit_in && state_in != INVALID;
    supply = hit && command != BUS_INVALIDATE && suppliesData(state_in);
    next_state = snoopNextState(command, state_in);
  end
endmodule

// File: rtl/moesif_snoopy_responder.sv
// moesif_snoopy_responder: snoop FSM that arbitrates for the cache port, supplies lines and
// downgrades or invalidates the local copy.
module moesif_snoopy_responder
  import moesif_snoopy_responder_pkg::*;
#(
  parameter int ADDRESS_WIDTH     = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int TAG_WIDTH         = 16,
  parameter int INDEX_WIDTH       = 8,
  parameter int OFFSET_WIDTH      = 8,
  parameter int SET_ASSOCIATIVITY = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     busCommandValid,
  input  BusCommand                busCommand,
  input  logic [ADDRESS_WIDTH-1:0] busAddress,
  output logic                     busRequestDone,
  output logic                     sharedOut,
  output logic                     ownedOut,
  output logic [DATA_WIDTH-1:0]    dataOut,
  output logic                     dataValid,
  input  logic                     dataAck,
  output logic                     snoopyRequest,
  input  logic                     snoopyGrant,
  output logic [TAG_WIDTH-1:0]     tagOut,
  output logic [INDEX_WIDTH-1:0]   indexOut,
  output logic [OFFSET_WIDTH-1:0]  offsetOut,
  input  logic                     cacheHit,
  input  CacheLineState            cacheStateIn,
  input  logic [DATA_WIDTH-1:0]    cacheDataIn,
  output CacheLineState            cacheStateOut,
  output logic                     cacheStateWrite
);
  localparam int LW = TAG_WIDTH + INDEX_WIDTH;
  snoop_state_t state_q, state_d;
  BusCommand cmd_q, cmd_d;
  CacheLineState new_state_q, new_state_d, next_state;
  logic [LW-1:0] addr_q, addr_d;
  logic [OFFSET_WIDTH-1:0] count_q, count_d;
  logic shared_q, shared_d, owned_q, owned_d, hit, supply;
  logic unused_addr;
  assign unused_addr = ^busAddress;
  moesif_snoop_state_update u_update (
    .command(cmd_q), .state_in(cacheStateIn), .hit_in(cacheHit),
    .hit(hit), .supply(supply), .next_state(next_state)
  );
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    addr_d = addr_q;
    count_d = count_q;
    shared_d = shared_q;
    owned_d = owned_q;
    new_state_d = new_state_q;
    case (state_q)
      IDLE: if (busCommandValid) begin
        state_d = ARBITRATE;
        cmd_d = busCommand;
        addr_d = busAddress[OFFSET_WIDTH +: LW];
      end
      ARBITRATE: if (snoopyGrant) state_d = LOOKUP;
      LOOKUP: if (snoopyGrant) begin
        shared_d = hit;
        owned_d = supply;
        count_d = '0;
        new_state_d = next_state;
        if (!hit) state_d = DONE;
        else if (supply) state_d = SUPPLY;
        else state_d = UPDATE;
      end
      SUPPLY: if (snoopyGrant && dataAck) begin
        count_d = count_q + OFFSET_WIDTH'(1);
        if (&count_q) state_d = UPDATE;
      end
      UPDATE: if (snoopyGrant) state_d = DONE;
      DONE: begin
        state_d = IDLE;
        shared_d = 1'b0;
        owned_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // a dropped grant freezes progress and suppresses the state write
  always_comb begin
    busRequestDone = state_q == DONE;
    sharedOut = shared_q;
    ownedOut = owned_q;
    dataValid = state_q == SUPPLY;
    dataOut = dataValid ? cacheDataIn : '0;
    snoopyRequest = state_q != IDLE;
    tagOut = addr_q[INDEX_WIDTH +: TAG_WIDTH];
    indexOut = addr_q[INDEX_WIDTH-1:0];
    offsetOut = count_q;
    cacheStateWrite = state_q == UPDATE && snoopyGrant;
    cacheStateOut = INVALID;
    if (state_q == UPDATE) cacheStateOut = new_state_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q <= BUS_READ;
      addr_q <= '0;
      count_q <= '0;
      shared_q <= 1'b0;
      owned_q <= 1'b0;
      new_state_q <= INVALID;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      addr_q <= addr_d;
      count_q <= count_d;
      shared_q <= shared_d;
      owned_q <= owned_d;
      new_state_q <= new_state_d;
    end
  end
endmodule
